// File: rtl/branch_resolve_bht_if.sv
// ID-stage branch resolution bundle: resolve request and IF lookup into the
// block, registered resolution result and combinational prediction out.
interface branch_resolve_bht_if #(
    parameter int WIDTH = 16
);
    logic             id_valid;
    logic             stall;
    logic             flush;
    logic [3:0]       opCode;
    logic [WIDTH-1:0] RD1;
    logic [WIDTH-1:0] R0R;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] offset;
    logic             pred_taken;
    logic [WIDTH-1:0] if_pc;
    logic             if_pred_taken;
    logic             br_valid;
    logic             br_taken;
    logic [WIDTH-1:0] br_next_pc;
    logic             mispredict;

    modport master (
        output id_valid, stall, flush, opCode, RD1, R0R, pc, offset,
               pred_taken, if_pc,
        input  if_pred_taken, br_valid, br_taken, br_next_pc, mispredict
    );

    modport slave (
        input  id_valid, stall, flush, opCode, RD1, R0R, pc, offset,
               pred_taken, if_pc,
        output if_pred_taken, br_valid, br_taken, br_next_pc, mispredict
    );
endinterface

// File: rtl/branch_resolve_bht.sv
// ID-stage BLT/BGT/BEQ/BNE resolver with registered next-PC and a 2-bit BHT.
// Define BRANCH_SIGNED_EN to make BLT/BGT compare signed two's complement.
module branch_resolve_bht #(
    parameter int WIDTH     = 16,
    parameter int BHT_DEPTH = 16,
    parameter int PC_INC    = 2
) (
    input logic                clk,
    input logic                rst_n,
    branch_resolve_bht_if.slave bus
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    localparam logic [3:0] OP_BLT = 4'b0100;
    localparam logic [3:0] OP_BGT = 4'b0101;
    localparam logic [3:0] OP_BEQ = 4'b0110;
    localparam logic [3:0] OP_BNE = 4'b0111;

    localparam logic [1:0] CTR_INIT = 2'b01;
    localparam logic [1:0] CTR_MAX  = 2'b11;
    localparam logic [1:0] CTR_MIN  = 2'b00;

    logic [1:0]       bht [BHT_DEPTH];
    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] update_idx;

    logic             is_branch;
    logic             resolve;
    logic             cond;
    logic             lt;
    logic             gt;
    logic             eq;
    logic [WIDTH-1:0] target_pc;
    logic [WIDTH-1:0] seq_pc;

    logic             br_valid_q;
    logic             br_taken_q;
    logic [WIDTH-1:0] br_next_pc_q;
    logic             mispredict_q;

    logic             unused_if_pc_bits;

    // PCs are 2-byte aligned, so bit 0 never selects an entry
    assign lookup_idx = bus.if_pc[IDX_W:1];
    assign update_idx = bus.pc[IDX_W:1];
    assign unused_if_pc_bits = ^bus.if_pc;

`ifdef BRANCH_SIGNED_EN
    assign lt = $signed(bus.RD1) < $signed(bus.R0R);
    assign gt = $signed(bus.RD1) > $signed(bus.R0R);
`else
    assign lt = bus.RD1 < bus.R0R;
    assign gt = bus.RD1 > bus.R0R;
`endif
    assign eq = bus.RD1 == bus.R0R;

    always_comb begin
        is_branch = 1'b0;
        cond      = 1'b0;
        case (bus.opCode)
            OP_BLT: begin is_branch = 1'b1; cond = lt;  end
            OP_BGT: begin is_branch = 1'b1; cond = gt;  end
            OP_BEQ: begin is_branch = 1'b1; cond = eq;  end
            OP_BNE: begin is_branch = 1'b1; cond = !eq; end
            default: begin is_branch = 1'b0; cond = 1'b0; end
        endcase
    end

    assign resolve   = bus.id_valid && !bus.stall && !bus.flush && is_branch;
    assign target_pc = bus.pc + bus.offset;
    assign seq_pc    = bus.pc + WIDTH'(PC_INC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_valid_q   <= 1'b0;
            br_taken_q   <= 1'b0;
            br_next_pc_q <= '0;
            mispredict_q <= 1'b0;
        end else if (resolve) begin
            br_valid_q   <= 1'b1;
            br_taken_q   <= cond;
            br_next_pc_q <= cond ? target_pc : seq_pc;
            mispredict_q <= cond ^ bus.pred_taken;
        end else begin
            br_valid_q   <= 1'b0;
            mispredict_q <= 1'b0;
        end
    end

    // Update lands on the result edge, so a same-index lookup sees the old value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
                bht[IDX_W'(i)] <= CTR_INIT;
            end
        end else if (resolve) begin
            if (cond) begin
                if (bht[update_idx] != CTR_MAX) begin
                    bht[update_idx] <= bht[update_idx] + 2'b01;
                end
            end else begin
                if (bht[update_idx] != CTR_MIN) begin
                    bht[update_idx] <= bht[update_idx] - 2'b01;
                end
            end
        end
    end

    assign bus.if_pred_taken = bht[lookup_idx][1];
    assign bus.br_valid      = br_valid_q;
    assign bus.br_taken      = br_taken_q;
    assign bus.br_next_pc    = br_next_pc_q;
    assign bus.mispredict    = mispredict_q;
endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed bench for branch_resolve_bht: resolution, wrap, BHT saturation,
// stall/flush/non-branch suppression, async reset and BLT signedness.
module tb_branch_resolve_bht;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    branch_resolve_bht_if #(.WIDTH(16)) bus ();

    branch_resolve_bht #(
        .WIDTH(16),
        .BHT_DEPTH(16),
        .PC_INC(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.id_valid   = 1'b0;
        bus.stall      = 1'b0;
        bus.flush      = 1'b0;
        bus.opCode     = 4'b0000;
        bus.pred_taken = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] p, input logic [15:0] off, input logic pt,
                         input logic st, input logic fl);
        @(negedge clk);
        bus.id_valid   = 1'b1;
        bus.stall      = st;
        bus.flush      = fl;
        bus.opCode     = op;
        bus.RD1        = a;
        bus.R0R        = b;
        bus.pc         = p;
        bus.offset     = off;
        bus.pred_taken = pt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pred_at(input string tag, input logic [15:0] a, input logic exp);
        bus.if_pc = a;
        #1;
        chk(tag, {31'd0, bus.if_pred_taken}, {31'd0, exp});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n          = 1'b1;
        bus.id_valid   = 1'b0;
        bus.stall      = 1'b0;
        bus.flush      = 1'b0;
        bus.opCode     = 4'b0000;
        bus.RD1        = '0;
        bus.R0R        = '0;
        bus.pc         = '0;
        bus.offset     = '0;
        bus.pred_taken = 1'b0;
        bus.if_pc      = '0;

        // asynchronous reset mid-cycle
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", {31'd0, bus.br_valid}, 32'd0);
        chk("rst_taken", {31'd0, bus.br_taken}, 32'd0);
        chk("rst_npc", {16'd0, bus.br_next_pc}, 32'd0);
        chk("rst_misp", {31'd0, bus.mispredict}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            pred_at("rst_bht", 16'(i * 2), 1'b0);
        end

        // BLT taken, mispredicted
        drive(4'b0100, 16'd3, 16'd5, 16'h0010, 16'h0020, 1'b0, 1'b0, 1'b0);
        step();
        chk("blt_valid", {31'd0, bus.br_valid}, 32'd1);
        chk("blt_taken", {31'd0, bus.br_taken}, 32'd1);
        chk("blt_npc", {16'd0, bus.br_next_pc}, 32'h0030);
        chk("blt_misp", {31'd0, bus.mispredict}, 32'd1);
        idle();
        chk("blt_pulse_end", {31'd0, bus.br_valid}, 32'd0);
        chk("blt_misp_end", {31'd0, bus.mispredict}, 32'd0);
        chk("blt_taken_hold", {31'd0, bus.br_taken}, 32'd1);
        chk("blt_npc_hold", {16'd0, bus.br_next_pc}, 32'h0030);
        pred_at("blt_bht", 16'h0010, 1'b1);

        // BNE not taken, sequential PC wraps to zero
        drive(4'b0111, 16'd7, 16'd7, 16'hFFFE, 16'h0100, 1'b0, 1'b0, 1'b0);
        step();
        chk("bne_valid", {31'd0, bus.br_valid}, 32'd1);
        chk("bne_taken", {31'd0, bus.br_taken}, 32'd0);
        chk("bne_npc_wrap", {16'd0, bus.br_next_pc}, 32'h0000);
        chk("bne_misp", {31'd0, bus.mispredict}, 32'd0);

        // BGT taken with negative offset
        drive(4'b0101, 16'd9, 16'd2, 16'h0100, 16'hFFF0, 1'b1, 1'b0, 1'b0);
        step();
        chk("bgt_taken", {31'd0, bus.br_taken}, 32'd1);
        chk("bgt_npc", {16'd0, bus.br_next_pc}, 32'h00F0);
        chk("bgt_misp", {31'd0, bus.mispredict}, 32'd0);

        // BLT with equal operands is not taken; predicted taken -> mispredict
        drive(4'b0100, 16'd4, 16'd4, 16'h0200, 16'h0040, 1'b1, 1'b0, 1'b0);
        step();
        chk("blt_eq_taken", {31'd0, bus.br_taken}, 32'd0);
        chk("blt_eq_npc", {16'd0, bus.br_next_pc}, 32'h0202);
        chk("blt_eq_misp", {31'd0, bus.mispredict}, 32'd1);

        // BHT saturation at pc 0x0004; lookup in the update cycle sees the old value
        idle();
        bus.if_pc = 16'h0004;
        drive(4'b0110, 16'd1, 16'd1, 16'h0004, 16'h0010, 1'b0, 1'b0, 1'b0);
        #1 chk("sat_t1_pre", {31'd0, bus.if_pred_taken}, 32'd0);
        step();
        chk("sat_t1_misp", {31'd0, bus.mispredict}, 32'd1);
        drive(4'b0110, 16'd1, 16'd1, 16'h0004, 16'h0010, 1'b1, 1'b0, 1'b0);
        #1 chk("sat_t2_pre", {31'd0, bus.if_pred_taken}, 32'd1);
        step();
        chk("sat_t2_misp", {31'd0, bus.mispredict}, 32'd0);
        drive(4'b0110, 16'd1, 16'd1, 16'h0004, 16'h0010, 1'b1, 1'b0, 1'b0);
        #1 chk("sat_t3_pre", {31'd0, bus.if_pred_taken}, 32'd1);
        step();
        drive(4'b0110, 16'd1, 16'd1, 16'h0004, 16'h0010, 1'b1, 1'b0, 1'b0);
        #1 chk("sat_t4_pre", {31'd0, bus.if_pred_taken}, 32'd1);
        step();
        // counter 11: not-taken walks it 10, 01, 00, then holds at 00
        drive(4'b0111, 16'd2, 16'd2, 16'h0004, 16'h0010, 1'b1, 1'b0, 1'b0);
        step();
        pred_at("sat_n1", 16'h0004, 1'b1);
        drive(4'b0111, 16'd2, 16'd2, 16'h0004, 16'h0010, 1'b1, 1'b0, 1'b0);
        step();
        pred_at("sat_n2", 16'h0004, 1'b0);
        drive(4'b0111, 16'd2, 16'd2, 16'h0004, 16'h0010, 1'b0, 1'b0, 1'b0);
        step();
        pred_at("sat_n3", 16'h0004, 1'b0);
        drive(4'b0111, 16'd2, 16'd2, 16'h0004, 16'h0010, 1'b0, 1'b0, 1'b0);
        step();
        drive(4'b0110, 16'd1, 16'd1, 16'h0004, 16'h0010, 1'b0, 1'b0, 1'b0);
        step();
        pred_at("sat_floor_t1", 16'h0004, 1'b0);
        drive(4'b0110, 16'd1, 16'd1, 16'h0004, 16'h0010, 1'b0, 1'b0, 1'b0);
        step();
        pred_at("sat_floor_t2", 16'h0004, 1'b1);
        chk("sat_npc", {16'd0, bus.br_next_pc}, 32'h0014);

        // stall, flush, non-branch and invalid produce no pulse and no BHT change
        drive(4'b0110, 16'd5, 16'd5, 16'h0008, 16'h0400, 1'b0, 1'b1, 1'b0);
        step();
        chk("stall_valid", {31'd0, bus.br_valid}, 32'd0);
        chk("stall_npc_hold", {16'd0, bus.br_next_pc}, 32'h0014);
        pred_at("stall_bht", 16'h0008, 1'b0);
        drive(4'b0110, 16'd5, 16'd5, 16'h0008, 16'h0400, 1'b0, 1'b0, 1'b1);
        step();
        chk("flush_valid", {31'd0, bus.br_valid}, 32'd0);
        pred_at("flush_bht", 16'h0008, 1'b0);
        drive(4'b0001, 16'd5, 16'd5, 16'h0008, 16'h0400, 1'b1, 1'b0, 1'b0);
        step();
        chk("nonbr_valid", {31'd0, bus.br_valid}, 32'd0);
        chk("nonbr_misp", {31'd0, bus.mispredict}, 32'd0);
        pred_at("nonbr_bht", 16'h0008, 1'b0);
        drive(4'b0110, 16'd5, 16'd5, 16'h0008, 16'h0400, 1'b0, 1'b0, 1'b0);
        bus.id_valid = 1'b0;
        step();
        chk("invalid_valid", {31'd0, bus.br_valid}, 32'd0);
        chk("hold_taken", {31'd0, bus.br_taken}, 32'd1);

        // BLT 0xFFFF vs 1 depends on signedness; BEQ/BNE unaffected
        drive(4'b0100, 16'hFFFF, 16'd1, 16'h0020, 16'h0010, 1'b0, 1'b0, 1'b0);
        step();
`ifdef BRANCH_SIGNED_EN
        chk("blt_sign_taken", {31'd0, bus.br_taken}, 32'd1);
        chk("blt_sign_npc", {16'd0, bus.br_next_pc}, 32'h0030);
`else
        chk("blt_sign_taken", {31'd0, bus.br_taken}, 32'd0);
        chk("blt_sign_npc", {16'd0, bus.br_next_pc}, 32'h0022);
`endif
        drive(4'b0101, 16'hFFFF, 16'd1, 16'h0020, 16'h0010, 1'b0, 1'b0, 1'b0);
        step();
`ifdef BRANCH_SIGNED_EN
        chk("bgt_sign_taken", {31'd0, bus.br_taken}, 32'd0);
`else
        chk("bgt_sign_taken", {31'd0, bus.br_taken}, 32'd1);
`endif

        // reset during a pending resolution discards it and restores the BHT
        drive(4'b0110, 16'd3, 16'd3, 16'h0010, 16'h0020, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, bus.br_valid}, 32'd0);
        chk("mid_rst_taken", {31'd0, bus.br_taken}, 32'd0);
        chk("mid_rst_npc", {16'd0, bus.br_next_pc}, 32'd0);
        chk("mid_rst_misp", {31'd0, bus.mispredict}, 32'd0);
        pred_at("mid_rst_bht10", 16'h0010, 1'b0);
        pred_at("mid_rst_bht04", 16'h0004, 1'b0);
        step();
        chk("rst_hold_valid", {31'd0, bus.br_valid}, 32'd0);
        @(negedge clk);
        bus.id_valid = 1'b0;
        rst_n = 1'b1;
        step();
        chk("post_rst_valid", {31'd0, bus.br_valid}, 32'd0);
        pred_at("post_rst_bht", 16'h0010, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/branch_resolve_bht.md
Name: branch_resolve_bht

Overview:
Parametrised successor to the ID-stage branch comparator. It resolves BLT/BGT/BEQ/BNE in ID and registers the next-PC result for the IF redirect. It also owns a branch history table (BHT) of 2-bit saturating counters. IF uses the table for prediction; the block updates it at resolution and flags mispredicts.

Parameters:
WIDTH, 16, datapath width of operands, pc, offset and next-PC
BHT_DEPTH, 16, number of BHT entries; power of two, >= 2
PC_INC, 2, sequential PC increment for not-taken branches

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  ID holds a valid instruction this cycle
stall  input  1  ID stalled; no resolution this cycle
flush  input  1  kill the ID instruction; no resolution, no BHT update
opCode  input  4  ID opcode
RD1  input  WIDTH  first compare operand
R0R  input  WIDTH  second compare operand
pc  input  WIDTH  PC of the ID instruction
offset  input  WIDTH  branch offset, two's complement
pred_taken  input  1  prediction IF made for this instruction
if_pc  input  WIDTH  IF-stage PC for lookup
if_pred_taken  output  1  combinational prediction for if_pc
br_valid  output  1  registered; one-cycle pulse when a branch resolved
br_taken  output  1  registered resolution outcome
br_next_pc  output  WIDTH  registered resolved next PC
mispredict  output  1  registered; br_taken != pred_taken, qualified by br_valid

Behaviour:
- Opcodes: 4'b0100 BLT (RD1<R0R); 4'b0101 BGT (RD1>R0R); 4'b0110 BEQ (==); 4'b0111 BNE (!=). All other opcodes are non-branch.
- Resolve condition: id_valid & ~stall & ~flush & branch opcode.
- Latency 1: on the clock edge after a resolve cycle, br_valid=1, br_taken=cond, br_next_pc = cond ? pc+offset : pc+PC_INC, mispredict = cond ^ pred_taken.
- In any cycle without a resolve condition, the next edge sets br_valid=0 and mispredict=0. br_taken and br_next_pc hold their last values.
- Adds are modulo 2^WIDTH; carry is discarded; wrap-around is silent.
- BHT index = address bits [log2(BHT_DEPTH):1], since PC is 2-byte aligned. if_pc is used for lookup; pc is used for update.
- if_pred_taken = bit 1 of the indexed counter; it is purely combinational.
- Update occurs at the same edge that registers the result. Counters saturate: taken increments up to 2'b11; not-taken decrements down to 2'b00.
- Same-index lookup and update in one cycle: lookup returns the pre-update value.
- Stall or flush suppress the update entirely; operands are not latched.
- Reset (async, any time, including mid-resolution):
  - br_valid=0, br_taken=0, br_next_pc=0, mispredict=0.
  - All BHT counters = 2'b01 (weakly not-taken).
  - Any pending result is discarded.
- Comparisons are unsigned by default.

Optional Feature:
BRANCH_SIGNED_EN: when defined, BLT/BGT compare RD1 and R0R as signed two's complement WIDTH-bit values. When undefined, they compare unsigned. BEQ/BNE are unaffected in both cases.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> all outputs 0 immediately; after release, if_pred_taken=0 for every if_pc.
- BLT taken: RD1=3, R0R=5, pc=16'h0010, offset=16'h0020, pred_taken=0 -> next edge br_valid=1, br_taken=1, br_next_pc=16'h0030, mispredict=1; br_valid=0 the following cycle.
- BNE not-taken with wrap: RD1=R0R=7, pc=16'hFFFE, pred_taken=0 -> br_next_pc=16'h0000, br_taken=0, mispredict=0.
- BHT saturation: same pc taken 4 times -> if_pred_taken goes 0,1,1,1 (counter 01→10→11→11); then 3 not-taken -> counter reaches 00, if_pred_taken=0.
- Stall/flush: BEQ equal operands with stall=1, then flush=1 -> br_valid stays 0 and the BHT entry is unchanged; non-branch opcode 4'b0001 -> no pulse.
- Signed (BRANCH_SIGNED_EN): BLT RD1=16'hFFFF, R0R=1 -> taken; without the macro -> not taken.
